// File: rtl/slt_pkg.sv
// slt_pkg: shared width constant and operand type for the set-less-than unit.
package slt_pkg;

  localparam int unsigned SLT_WIDTH = 64;

  typedef logic [SLT_WIDTH-1:0] slt_word_t;

endpackage : slt_pkg

// File: rtl/slt_sub.sv
// slt_sub: WIDTH-bit subtractor a - b computed as a + ~b + 1, built from 4-bit
// carry-lookahead groups whose group carries ripple from group to group.
module slt_sub
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             cout
);

  localparam int unsigned NGRP = (WIDTH + 3) / 4;
  localparam int unsigned PW   = NGRP * 4;

  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [PW:0]   c;
  logic          carry_unused;

  // Per-bit generate/propagate against the inverted subtrahend; pad bits stay 0.
  always_comb begin
    g = '0;
    p = '0;
    g[WIDTH-1:0] = a & ~b;
    p[WIDTH-1:0] = a ^ ~b;
  end

  // Lookahead inside each 4-bit group, group carry-in taken from the group below.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int unsigned k = 0; k < NGRP; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign d    = p[WIDTH-1:0] ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

  // Carries above the operand width only exist because of group padding.
  assign carry_unused = ^c[PW:WIDTH];

endmodule : slt_sub

// File: rtl/slt.sv
// slt: registered signed set-less-than (A < B) via subtract-and-overflow.
// Optional macro SLT_SLTU_EN adds the Unsigned input selecting an unsigned compare.
module slt
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SLT_SLTU_EN
  input  logic             Unsigned,
`endif
  output logic             Result
);

  logic [WIDTH-1:0] d;
  logic             c;
  logic             s;
  logic             v;
  logic             lt_s;
  logic             lt;
  logic             sub_unused;

  slt_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a    (A),
    .b    (B),
    .d    (d),
    .cout (c)
  );

  // Signed verdict: difference sign corrected by overflow.
  always_comb begin
    s    = d[WIDTH-1];
    v    = (A[WIDTH-1] != B[WIDTH-1]) && (s != A[WIDTH-1]);
    lt_s = s ^ v;
  end

`ifdef SLT_SLTU_EN
  // Borrow (no carry-out) means A < B unsigned.
  always_comb begin
    lt = Unsigned ? ~c : lt_s;
  end
  assign sub_unused = ^d[WIDTH-2:0];
`else
  // Signed-only build: carry-out is not consumed.
  always_comb begin
    lt = lt_s;
  end
  assign sub_unused = ^{d[WIDTH-2:0], c};
`endif

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Result <= 1'b0;
    else        Result <= lt;
  end

endmodule : slt

// File: tb/tb_slt.sv
// tb_slt: directed self-checking bench for slt with a behavioural compare model.
module tb_slt;
  import slt_pkg::*;

  logic      clk;
  logic      rst_n;
  slt_word_t a;
  slt_word_t b;
  logic      uns;
  logic      result;

  logic      exp_q;
  logic      chk_en;
  int        n_checks;
  int        n_errors;

  slt #(
    .WIDTH (SLT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
`ifdef SLT_SLTU_EN
    .Unsigned (uns),
`endif
    .Result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_lt(slt_word_t x, slt_word_t y, logic u);
    if (u) return x < y;
    return $signed(x) < $signed(y);
  endfunction

  // Reference: the compare result one cycle after sampling, zero under reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 1'b0;
    else        exp_q <= model_lt(a, b, uns);
  end

  task automatic check(input string name, input logic act, input logic want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, want, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) check("cycle", result, exp_q);
  end

  // One operand pair per cycle; checks DUT and model against a literal.
  task automatic apply(input string name, input slt_word_t x, input slt_word_t y,
                       input logic u, input logic want);
    @(negedge clk);
    a   = x;
    b   = y;
    uns = u;
    @(posedge clk);
    #1;
    check(name, result, want);
    check({name, "_model"}, exp_q, want);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    uns      = 1'b0;

    #12;
    check("reset_state", result, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    apply("small_lt",   64'h5, 64'hA, 1'b0, 1'b1);
    apply("small_gt",   64'hA, 64'h5, 1'b0, 1'b0);
    apply("neg_lt",     64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1);
    apply("neg1_lt_0",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
    apply("eq_zero",    64'h0, 64'h0, 1'b0, 1'b0);
    apply("eq_min",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    apply("min_lt_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    apply("max_lt_min", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    apply("max_lt_m1",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    apply("carry_hi",   64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    apply("carry_lo",   64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b1);
    apply("mid_grp",    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDF0, 1'b0, 1'b1);

    // Asynchronous reset while Result is high, between clock edges.
    apply("pre_reset",  64'h5, 64'hA, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", result, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", result, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset", 64'h5, 64'hA, 1'b0, 1'b1);

`ifdef SLT_SLTU_EN
    apply("u_m1_lt_0",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    apply("u_0_lt_m1",  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    apply("u_min_max",  64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    apply("u_eq",       64'h1234, 64'h1234, 1'b1, 1'b0);
    apply("s_after_u",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
    apply("u_small",    64'h5, 64'hA, 1'b1, 1'b1);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_slt
